// File: rtl/sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl
//   Framed serial-in parallel-out receiver. A '1' on data_i while idle marks the
//   start of a frame; the next WIDTH strobed bits are shifted in and the
//   completed word is handed to a one-entry output buffer with a valid/ready
//   handshake. A word that completes while the buffer is still occupied and
//   not being accepted is dropped and flagged on overrun_o.
//
//   Optional feature macro: SIPO_PARITY_EN
//     When defined, one even-parity bit follows the data bits. A mismatch
//     pulses parity_err_o during DONE, and the word is still delivered.
//     When undefined, there is no parity state and parity_err_o is tied to 0.
// -----------------------------------------------------------------------------
module sipo_frame_ctrl #(
  parameter int WIDTH     = 4,    // data bits per frame, 2..32
  parameter bit MSB_FIRST = 1'b1  // 1: first data bit lands in data_o[WIDTH-1]
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             bit_en_i,
  input  logic             data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             parity_err_o
);

  // Wide enough to hold WIDTH itself, so the counter never wraps.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_DONE   = 2'd2
`ifdef SIPO_PARITY_EN
    ,
    S_PARITY = 2'd3
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
`ifdef SIPO_PARITY_EN
  logic             perr_q,  perr_d;
`endif

  logic [WIDTH-1:0] shift_in;
  logic             last_bit;
  logic             done;
  logic             load;

  // Shift register contents after taking data_i, in the configured direction.
  always_comb begin
    if (MSB_FIRST) begin
      shift_in = {shift_q[WIDTH-2:0], data_i};
    end else begin
      shift_in = {data_i, shift_q[WIDTH-1:1]};
    end
  end

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign done     = (state_q == S_DONE);
  // A finished word goes into the buffer if it is empty or being drained now.
  assign load     = done && (!valid_q || ready_i);

  // Frame FSM: start detection, bit counting and the single-cycle DONE state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef SIPO_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bit_en_i && data_i) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        if (bit_en_i) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + CW'(1);
          if (last_bit) begin
`ifdef SIPO_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef SIPO_PARITY_EN
      S_PARITY: begin
        if (bit_en_i) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          perr_d  = (^shift_q) ^ data_i;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        // Strobe is ignored here; the frame is committed or dropped this cycle.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output buffer: load on commit, clear on a handshake with nothing new.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = shift_q;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset discards any partial frame and empties the buffer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef SIPO_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef SIPO_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign busy_o    = (state_q != S_IDLE);
  // DONE lasts one cycle, so these are single-cycle pulses by construction.
  assign overrun_o = done && valid_q && !ready_i;
`ifdef SIPO_PARITY_EN
  assign parity_err_o = done && perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
